// File: rtl/glyph_plotter.sv
// glyph_plotter: rasterises an 8x16 glyph into one pixel write per cycle (in: START/GLYPH/origin/FG/BG/WAIT; out: X/Y/COLOUR/PLOT/BUSY/DONE)
module glyph_plotter #(
  parameter int X_W = 8,
  parameter int Y_W = 7,
  parameter int COLOUR_W = 3,
  parameter bit TRANSPARENT_BG = 1'b0
) (
  input  logic                CLK,
  input  logic                RESET,
  input  logic                START,
  input  logic [127:0]        GLYPH,
  input  logic [X_W-1:0]      X_ORIGIN,
  input  logic [Y_W-1:0]      Y_ORIGIN,
  input  logic [COLOUR_W-1:0] FG,
  input  logic [COLOUR_W-1:0] BG,
  input  logic                WAIT,
  output logic [X_W-1:0]      X,
  output logic [Y_W-1:0]      Y,
  output logic [COLOUR_W-1:0] COLOUR,
  output logic                PLOT,
  output logic                BUSY,
  output logic                DONE
);
  typedef enum logic [1:0] {IDLE, DRAW, FINISH} state_t;
  state_t state;
  logic [6:0] n;
  logic [127:0] g;
  logic [X_W-1:0] xo;
  logic [Y_W-1:0] yo;
  logic [COLOUR_W-1:0] fg, bg;
  logic idle, b, pl;
  logic [6:0] m, mi;
  logic [127:0] gs;
  logic [X_W-1:0] px;
  logic [Y_W-1:0] py;
  logic [COLOUR_W-1:0] cs;
  always_comb begin
    idle = state == IDLE;
    m = idle ? 7'd0 : n + 7'd1;
    mi = ~m;
    gs = idle ? GLYPH : g;
    b = gs[mi];
    px = (idle ? X_ORIGIN : xo) + X_W'(m[2:0]);
    py = (idle ? Y_ORIGIN : yo) + Y_W'(m[6:3]);
    cs = b ? (idle ? FG : fg) : (idle ? BG : bg);
    pl = b || !TRANSPARENT_BG;
  end
  always_ff @(posedge CLK or posedge RESET)
    if (RESET) begin
      state <= IDLE;
      n <= '0;
      g <= '0;
      xo <= '0;
      yo <= '0;
      fg <= '0;
      bg <= '0;
      X <= '0;
      Y <= '0;
      COLOUR <= '0;
      PLOT <= 1'b0;
      BUSY <= 1'b0;
      DONE <= 1'b0;
    end else
      case (state)
        IDLE:
          if (START) begin
            g <= GLYPH;
            xo <= X_ORIGIN;
            yo <= Y_ORIGIN;
            fg <= FG;
            bg <= BG;
            n <= '0;
            X <= px;
            Y <= py;
            COLOUR <= cs;
            PLOT <= pl;
            BUSY <= 1'b1;
            state <= DRAW;
          end
        DRAW:
          if (!PLOT || !WAIT) begin
            if (n == 7'd127) begin
              PLOT <= 1'b0;
              DONE <= 1'b1;
              state <= FINISH;
            end else begin
              n <= m;
              X <= px;
              Y <= py;
              COLOUR <= cs;
              PLOT <= pl;
            end
          end
        FINISH: begin
          DONE <= 1'b0;
          BUSY <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
endmodule

// File: tb/tb_glyph_plotter.sv
// tb_glyph_plotter: directed checks of glyph_plotter with opaque and transparent background instances
module tb_glyph_plotter;
  logic CLK = 1'b0, RESET = 1'b1, START = 1'b0, WAIT = 1'b0;
  logic [127:0] GLYPH = '0;
  logic [7:0] X_ORIGIN = '0;
  logic [6:0] Y_ORIGIN = '0;
  logic [2:0] FG = '0, BG = '0;
  logic [7:0] x0, x1;
  logic [6:0] y0, y1;
  logic [2:0] c0, c1;
  logic p0, p1, b0, b1, d0, d1;
  int total = 0, fails = 0;
  int done_cyc, p1cnt, extra_done;
  int p1cyc [2];
  logic [7:0] sx [128];
  logic [6:0] sy [128];
  logic [2:0] sc [128];
  localparam logic [127:0] ONES = '1;
  localparam logic [127:0] ROW81 = {8'h81, 120'd0};
  always #5 CLK = ~CLK;
  glyph_plotter #(.TRANSPARENT_BG(1'b0)) dut0 (.CLK(CLK), .RESET(RESET), .START(START), .GLYPH(GLYPH),
    .X_ORIGIN(X_ORIGIN), .Y_ORIGIN(Y_ORIGIN), .FG(FG), .BG(BG), .WAIT(WAIT),
    .X(x0), .Y(y0), .COLOUR(c0), .PLOT(p0), .BUSY(b0), .DONE(d0));
  glyph_plotter #(.TRANSPARENT_BG(1'b1)) dut1 (.CLK(CLK), .RESET(RESET), .START(START), .GLYPH(GLYPH),
    .X_ORIGIN(X_ORIGIN), .Y_ORIGIN(Y_ORIGIN), .FG(FG), .BG(BG), .WAIT(WAIT),
    .X(x1), .Y(y1), .COLOUR(c1), .PLOT(p1), .BUSY(b1), .DONE(d1));
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic start_draw(input logic [127:0] gl, input logic [7:0] xo, input logic [6:0] yo,
                            input logic [2:0] fg, input logic [2:0] bg, input bit hold);
    int t = 0;
    while ((b0 || b1) && t < 300) begin
      @(negedge CLK);
      t++;
    end
    if (t >= 300) chk("idle_timeout", 64'(t), 64'd0);
    GLYPH = gl;
    X_ORIGIN = xo;
    Y_ORIGIN = yo;
    FG = fg;
    BG = bg;
    START = 1'b1;
    @(negedge CLK);
    START = hold;
    GLYPH = ~gl;
    X_ORIGIN = xo + 8'd77;
    Y_ORIGIN = yo + 7'd33;
    FG = ~fg;
    BG = ~bg;
  endtask
  task automatic run(input logic [127:0] gl, input logic [7:0] xo, input logic [6:0] yo,
                     input logic [2:0] fg, input logic [2:0] bg,
                     input int stall_at, input int stall_len, input bit hold);
    int k = 0, cyc = 1, stalled = 0;
    logic [7:0] ex;
    logic [6:0] ey;
    logic [2:0] ec;
    p1cnt = 0;
    p1cyc[0] = 0;
    p1cyc[1] = 0;
    start_draw(gl, xo, yo, fg, bg, hold);
    while (k < 128) begin
      ex = xo + 8'(k % 8);
      ey = yo + 7'(k / 8);
      ec = gl[127 - k] ? fg : bg;
      chk($sformatf("pix%0d_c%0d", k, cyc), {x0, y0, c0, p0, b0, d0}, {ex, ey, ec, 1'b1, 1'b1, 1'b0});
      sx[k] = x0;
      sy[k] = y0;
      sc[k] = c0;
      if (p1) begin
        if (p1cnt < 2) p1cyc[p1cnt] = cyc;
        p1cnt++;
      end
      if (k == stall_at && stalled < stall_len) begin
        WAIT = 1'b1;
        stalled++;
      end else begin
        WAIT = 1'b0;
        k++;
      end
      @(negedge CLK);
      cyc++;
    end
    done_cyc = cyc;
    chk("done_cycle", {p0, b0, d0, d1}, 4'b0111);
    START = 1'b0;
    @(negedge CLK);
    chk("idle_after_done", {p0, b0, d0, b1, d1}, 5'b0);
    extra_done = 0;
    repeat (10) begin
      @(negedge CLK);
      extra_done += int'(d0) + int'(b0);
    end
  endtask
  initial begin
    @(negedge CLK);
    chk("reset_outputs", {x0, y0, c0, p0, b0, d0}, 64'd0);
    chk("reset_outputs_t", {x1, y1, c1, p1, b1, d1}, 64'd0);
    RESET = 1'b0;
    @(negedge CLK);
    chk("idle_no_start", {p0, b0, d0}, 3'b000);
    run(ONES, 8'd10, 7'd20, 3'd7, 3'd0, -1, 0, 1'b0);
    chk("first_xy", {sx[0], sy[0]}, {8'd10, 7'd20});
    chk("pix8_xy", {sx[8], sy[8]}, {8'd10, 7'd21});
    chk("last_xy", {sx[127], sy[127]}, {8'd17, 7'd35});
    chk("ones_colour", sc[64], 3'd7);
    chk("ones_done_cyc", done_cyc, 129);
    chk("ones_t_plots", p1cnt, 128);
    run(ROW81, 8'd40, 7'd5, 3'd2, 3'd1, -1, 0, 1'b0);
    chk("row81_c0", {sx[0], sy[0], sc[0]}, {8'd40, 7'd5, 3'd2});
    chk("row81_c7", {sx[7], sy[7], sc[7]}, {8'd47, 7'd5, 3'd2});
    chk("row81_bg1", sc[1], 3'd1);
    chk("row81_bg100", sc[100], 3'd1);
    chk("transp_pulses", p1cnt, 2);
    chk("transp_cyc_a", p1cyc[0], 1);
    chk("transp_cyc_b", p1cyc[1], 8);
    chk("transp_done_cyc", done_cyc, 129);
    run(ONES, 8'd0, 7'd0, 3'd5, 3'd0, 3, 5, 1'b0);
    chk("stall_done_cyc", done_cyc, 134);
    chk("stall_resume", {sx[4], sc[4]}, {8'd4, 3'd5});
    run(ONES, 8'd252, 7'd120, 3'd6, 3'd0, -1, 0, 1'b0);
    chk("wrap_x3", sx[3], 8'd255);
    chk("wrap_x4", sx[4], 8'd0);
    chk("wrap_x7", {sx[7], sy[7]}, {8'd3, 7'd120});
    chk("wrap_y63", sy[63], 7'd127);
    chk("wrap_y64", sy[64], 7'd0);
    start_draw(ONES, 8'd30, 7'd40, 3'd4, 3'd0, 1'b0);
    repeat (50) @(negedge CLK);
    chk("pre_reset_pix50", {x0, y0, p0, b0}, {8'd32, 7'd46, 1'b1, 1'b1});
    RESET = 1'b1;
    #1;
    chk("async_reset", {x0, y0, c0, p0, b0, d0}, 64'd0);
    chk("async_reset_t", {x1, y1, c1, p1, b1, d1}, 64'd0);
    @(negedge CLK);
    RESET = 1'b0;
    run(ONES, 8'd30, 7'd40, 3'd4, 3'd0, -1, 0, 1'b0);
    chk("restart_pix0", {sx[0], sy[0]}, {8'd30, 7'd40});
    chk("restart_done_cyc", done_cyc, 129);
    run(ONES, 8'd1, 7'd2, 3'd3, 3'd0, -1, 0, 1'b1);
    chk("held_start_done_cyc", done_cyc, 129);
    chk("held_start_no_redraw", extra_done, 0);
    $display("%0d/%0d checks passed", total - fails, total);
    $finish;
  end
endmodule
